// File: rtl/fetch_aligner_pkg.sv
// Shared types and helpers for the fetch aligner.
// The low two bits of a halfword mark an RVC instruction unless they are 2'b11.
package fetch_aligner_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int HALF_WIDTH        = 16;

  typedef enum logic [1:0] {
    S_ALIGNED = 2'd0,
    S_HALF    = 2'd1,
    S_SKIP    = 2'd2
  } fa_state_e;

  function automatic logic is_rvc(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction
endpackage

// File: rtl/fa_out_stage.sv
// Valid/ready pipeline register with a one-entry skid: +1 cycle latency, full throughput.
// in_ready_o comes straight from a flop, so upstream never sees out_ready_i combinationally.
module fa_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [W-1:0] out_dat_q, out_dat_d, skid_dat_q, skid_dat_d;

  assign in_ready_o  = ~skid_vld_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_dat_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_ready_i) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_valid_i;
        out_dat_d = in_data_i;
      end
    end else if (in_valid_i && !skid_vld_q) begin
      // Output is stalled: park the word that was accepted against last cycle's ready.
      skid_vld_d = 1'b1;
      skid_dat_d = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end
endmodule

// File: rtl/fetch_aligner.sv
// Splits 32-bit fetch words into RVC/32-bit instructions with PCs; 0-cycle combinational path.
// FA_SKID_EN adds a registered output stage (+1 cycle); redirect flushes everything that cycle.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_word,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [XLEN-1:0]              out_pc,
  output logic                         out_is_rvc
);
  localparam int OW = INSTRUCTION_WIDTH + XLEN + 1;

  fa_state_e                    state_q, state_d;
  logic [XLEN-1:0]              pc_q, pc_d;
  logic [HALF_WIDTH-1:0]        hold_q, hold_d;
  logic                         core_vld, core_rdy, core_in_rdy, core_rvc;
  logic [INSTRUCTION_WIDTH-1:0] core_instr;

  // pc_q is always the PC of the next instruction; in S_HALF it is the held halfword's PC.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    core_vld    = 1'b0;
    core_in_rdy = 1'b0;
    core_rvc    = 1'b0;
    core_instr  = '0;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(1);
      hold_d  = '0;
      state_d = redirect_pc[1] ? S_SKIP : S_ALIGNED;
    end else begin
      case (state_q)
        S_ALIGNED: begin
          core_in_rdy = core_rdy;
          core_vld    = in_valid;
          core_rvc    = is_rvc(in_word[1:0]);
          core_instr  = core_rvc ? {16'h0, in_word[15:0]} : in_word;
          if (in_valid && core_rdy) begin
            if (core_rvc) begin
              hold_d  = in_word[31:16];
              pc_d    = pc_q + XLEN'(2);
              state_d = S_HALF;
            end else begin
              pc_d = pc_q + XLEN'(4);
            end
          end
        end
        S_HALF: begin
          if (is_rvc(hold_q[1:0])) begin
            core_vld   = 1'b1;
            core_rvc   = 1'b1;
            core_instr = {16'h0, hold_q};
            if (core_rdy) begin
              pc_d    = pc_q + XLEN'(2);
              state_d = S_ALIGNED;
            end
          end else begin
            core_in_rdy = core_rdy;
            core_vld    = in_valid;
            core_instr  = {in_word[15:0], hold_q};
            if (in_valid && core_rdy) begin
              hold_d = in_word[31:16];
              pc_d   = pc_q + XLEN'(4);
            end
          end
        end
        S_SKIP: begin
          core_in_rdy = 1'b1;
          if (in_valid) begin
            hold_d  = in_word[31:16];
            state_d = S_HALF;
          end
        end
        default: state_d = S_ALIGNED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ALIGNED;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  assign in_ready = core_in_rdy & rst_n;

`ifdef FA_SKID_EN
  logic          stg_vld;
  logic [OW-1:0] stg_dat;

  fa_out_stage #(.W(OW)) u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .in_valid_i (core_vld),
    .in_ready_o (core_rdy),
    .in_data_i  ({core_instr, pc_q, core_rvc}),
    .out_valid_o(stg_vld),
    .out_ready_i(out_ready),
    .out_data_o (stg_dat)
  );

  assign out_valid = stg_vld & ~redirect_valid & rst_n;
  assign {out_instr, out_pc, out_is_rvc} = out_valid ? stg_dat : '0;
`else
  assign core_rdy  = out_ready;
  assign out_valid = core_vld & rst_n;
  assign {out_instr, out_pc, out_is_rvc} = out_valid ? {core_instr, pc_q, core_rvc} : OW'(0);
`endif
endmodule

// File: tb/tb_fetch_aligner.sv
// Random fetch streams and redirects against a halfword-walking program model.
module tb_fetch_aligner;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, redirect_valid = 1'b0;
  logic        out_valid, out_ready = 1'b0, out_is_rvc;
  logic [31:0] in_word = '0, redirect_pc = '0, out_instr, out_pc;

  always #5 clk = ~clk;

  fetch_aligner #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_word       (in_word),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_is_rvc    (out_is_rvc)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] fetch_addr = '0;
  int          compared = 0, mismatched = 0, popped = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Program image, filled lazily; about half the halfwords start a 32-bit instruction.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] wa, w;
    wa = a & ~32'h3;
    if (!mem.exists(wa)) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
      mem[wa] = w;
    end
    return mem[wa];
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Expected instruction sequence starting at pc: walk memory halfword by halfword.
  task automatic load_expect(input logic [31:0] start, input int n);
    logic [31:0] p;
    logic [15:0] lo, hi;
    exp_t        e;
    p = start;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      lo = half_at(p);
      if (lo[1:0] != 2'b11) begin
        e.instr = {16'h0, lo}; e.pc = p; e.rvc = 1'b1;
        p = p + 32'd2;
      end else begin
        hi = half_at(p + 32'd2);
        e.instr = {hi, lo}; e.pc = p; e.rvc = 1'b0;
        p = p + 32'd4;
      end
      exp_q.push_back(e);
    end
  endtask

  exp_t cur, prev, e_pop;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      cur = {out_instr, out_pc, out_is_rvc};
      if (redirect_valid) begin
        chk("redirect_gate", {out_valid, in_ready}, 2'b00);
        prev_stall = 1'b0;
      end else if (out_valid) begin
        if (prev_stall) chk("stall_stable", cur, prev);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", cur, '0);
          end else begin
            e_pop = exp_q.pop_front();
            chk("instr", cur, e_pop);
          end
          popped++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev = cur;
        end
      end else if (prev_stall) begin
        chk("stall_drop", out_valid, 1'b1);
        prev_stall = 1'b0;
      end
    end
  end

  task automatic run_segment(input int target, input bit stall_win);
    int   cyc, start_pop;
    logic acc;
    cyc = 0; acc = 1'b0; start_pop = popped;
    while (popped - start_pop < target) begin
      @(posedge clk);
      if (acc) fetch_addr = fetch_addr + 32'd4;
      #1;
      redirect_valid = 1'b0;
      if (!in_valid || acc) in_valid = ($urandom_range(0, 9) < 8);
      in_word = word_at(fetch_addr);
      if (stall_win && cyc >= 6 && cyc < 11) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 9) < 8);
      @(negedge clk);
      acc = in_valid & in_ready;
      cyc++;
      if (cyc > 400) begin
        chk("segment_timeout", 65'(popped - start_pop), 65'(target));
        break;
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] tpc, input bit with_valid);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = tpc;
    in_valid       = with_valid;
    in_word        = $urandom;
    out_ready      = ($urandom_range(0, 1) == 1);
    fetch_addr     = tpc & ~32'h3;
    load_expect(tpc & ~32'h1, 48);
    @(negedge clk);
  endtask

  initial begin
    mem[32'h0000_0000] = 32'h00A0_0093;
    mem[32'h0000_0004] = 32'h0010_8113;
    mem[32'h0000_0008] = 32'h4505_0505;
    mem[32'h0000_000C] = 32'h0093_4505;
    mem[32'h0000_0010] = 32'h0000_00A0;
    mem[32'h0000_0014] = 32'h0000_0000;
    mem[32'h0000_0100] = 32'h0505_FFFF;
    load_expect(32'h0, 48);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_is_rvc", out_is_rvc, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_segment(8, 1'b1);
    do_redirect(32'h0000_0103, 1'b1);
    run_segment(6, 1'b0);
    do_redirect(32'hFFFF_FFF8, 1'b0);
    run_segment(10, 1'b0);
    for (int s = 0; s < 25; s++) begin
      do_redirect($urandom, ($urandom_range(0, 1) == 1));
      run_segment($urandom_range(1, 30), ($urandom_range(0, 3) == 0));
    end
    do_redirect(32'h0, 1'b0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
